// File: rtl/popcount_unary_serializer_if.sv
// Handshake bundle for popcount_unary_serializer: count-word input channel and serial-bit output channel.
// Ports: in_valid/in_ready/in_count (count word), out_valid/out_ready/out_bit/out_last/out_word (stream), sat_err.
// slave = serializer view, master = producer/consumer view.
interface popcount_unary_serializer_if #(
    parameter int N  = 7,
    parameter int CW = $clog2(N + 1)
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_count;
    logic          out_valid;
    logic          out_ready;
    logic          out_bit;
    logic          out_last;
    logic [N-1:0]  out_word;
    logic          sat_err;

    modport slave (
        input  in_valid, in_count, out_ready,
        output in_ready, out_valid, out_bit, out_last, out_word, sat_err
    );

    modport master (
        output in_valid, in_count, out_ready,
        input  in_ready, out_valid, out_bit, out_last, out_word, sat_err
    );
endinterface

// File: rtl/popcount_unary_serializer.sv
// Serialises an N-bit thermometer word holding exactly min(in_count,N) ones, LSB first, one bit per beat.
// Latency: first beat valid 1 cycle after acceptance; N cycles per word, back-to-back words with no bubble.
// Backpressure: beats hold while out_ready=0; in_ready only in IDLE or on the completing last beat.
// Ports: clk, rst_n (synchronous, active-low), bus (popcount_unary_serializer_if.slave).
// Optional macro POPCOUNT_SER_ROTATE_EN: the run of ones starts at a rotation offset that advances per word.
module popcount_unary_serializer #(
    parameter int N  = 7,
    parameter int CW = $clog2(N + 1)
) (
    input  logic clk,
    input  logic rst_n,
    popcount_unary_serializer_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  word, word_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic          sat, sat_nxt;
    logic [IW-1:0] off, off_nxt;
    logic [CW-1:0] cnt_sat;
    logic          over;
    logic          last;
    logic          beat;
    logic          accept;

    // Ones occupy positions off, off+1, ... wrapping modulo N.
    function automatic logic [N-1:0] therm(input logic [CW-1:0] c, input logic [IW-1:0] o);
        logic [N-1:0] w;
        int           d;
        w = '0;
        for (int i = 0; i < N; i++) begin
            d = i - int'(o);
            if (d < 0) d = d + N;
            w[i] = (d < int'(c));
        end
        return w;
    endfunction

    always_comb begin
        over          = int'(bus.in_count) > N;
        cnt_sat       = over ? CW'(N) : bus.in_count;
        last          = (idx == IW'(N - 1));
        beat          = (state == SHIFT) && bus.out_ready;
        bus.out_valid = (state == SHIFT);
        bus.out_bit   = (state == SHIFT) ? word[idx] : 1'b0;
        bus.out_last  = (state == SHIFT) && last;
        // The completing last beat frees the slot, so a new word can start without an IDLE visit.
        bus.in_ready  = (state == IDLE) || (beat && last);
        accept        = bus.in_valid && bus.in_ready;

`ifdef POPCOUNT_SER_ROTATE_EN
        off_nxt = off;
        if (beat && last) off_nxt = (off == IW'(N - 1)) ? '0 : off + 1'b1;
`else
        off_nxt = '0;
`endif

        state_nxt = state;
        word_nxt  = word;
        idx_nxt   = idx;
        sat_nxt   = accept && over;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    word_nxt  = therm(cnt_sat, off_nxt);
                    idx_nxt   = '0;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (last) begin
                        idx_nxt = '0;
                        if (accept) begin
                            // Built with the already-advanced offset of the word that starts now.
                            word_nxt = therm(cnt_sat, off_nxt);
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word <= '0;
            idx  <= '0;
            sat  <= 1'b0;
        end else begin
            word <= word_nxt;
            idx  <= idx_nxt;
            sat  <= sat_nxt;
        end
    end

`ifdef POPCOUNT_SER_ROTATE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) off <= '0;
        else        off <= off_nxt;
    end
`else
    assign off = '0;
`endif

    assign bus.out_word = word;
    assign bus.sat_err  = sat;
endmodule

// File: tb/tb_popcount_unary_serializer.sv
// Directed bench for popcount_unary_serializer (N=7, CW=4 so over-range counts can be offered).
// Expected beats are queued on acceptance and popped as beats are taken.
// Prints one summary line at the end.
module tb_popcount_unary_serializer;
`ifdef POPCOUNT_SER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct {
        logic       b;
        logic       l;
        logic [6:0] w;
        int         cnt;
    } beat_t;

    logic clk;
    logic rst_n;
    popcount_unary_serializer_if #(.N(7), .CW(4)) bus ();

    popcount_unary_serializer #(.N(7), .CW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t sb[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    model_off   = 0;
    int    ones        = 0;
    int    cyc         = 0;
    logic  exp_sat     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] model_word(input int c, input int o);
        logic [6:0] w;
        for (int i = 0; i < 7; i++) w[i] = (((i - o + 7) % 7) < c);
        return w;
    endfunction

    // One clock: drive inputs just after a falling edge, check settled outputs, update the model.
    task automatic cycle(input logic v, input logic [3:0] c, input logic r, output logic acc);
        beat_t e;
        logic  exp_rdy;
        int    cs;
        bus.in_valid  = v;
        bus.in_count  = c;
        bus.out_ready = r;
        #1;
        acc     = 1'b0;
        exp_rdy = (sb.size() == 0) || (sb.size() == 1 && r);
        chk("out_valid", bus.out_valid, sb.size() > 0);
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("sat_err", bus.sat_err, exp_sat);
        exp_sat = 1'b0;
        if (sb.size() > 0) begin
            e = sb[0];
            chk("out_bit", bus.out_bit, e.b);
            chk("out_last", bus.out_last, e.l);
            chk("out_word", bus.out_word, e.w);
            if (r) begin
                void'(sb.pop_front());
                ones += int'(e.b);
                if (e.l) begin
                    chk("word_popcount", ones, e.cnt);
                    ones = 0;
                    if (ROT) model_off = (model_off + 1) % 7;
                end
            end
        end
        if (v && exp_rdy) begin
            acc     = 1'b1;
            exp_sat = (c > 4'd7);
            cs      = exp_sat ? 7 : int'(c);
            for (int i = 0; i < 7; i++) begin
                e.w   = model_word(cs, model_off);
                e.b   = e.w[i];
                e.l   = (i == 6);
                e.cnt = cs;
                sb.push_back(e);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 40 && sb.size() > 0; i++) cycle(1'b0, 4'd0, 1'b1, acc);
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_count  = 4'd0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        exp_sat   = 1'b0;
        model_off = 0;
        ones      = 0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_word", bus.out_word, 7'd0);
        chk("rst_out_bit", bus.out_bit, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_sat_err", bus.sat_err, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        logic       acc;
        int         t0;
        int         t1;
        logic [6:0] exp6 [3];

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_count  = 4'd0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // 1: count 3 with the consumer always ready.
        cycle(1'b1, 4'd3, 1'b1, acc);
        chk("t1_accept", acc, 1'b1);
        chk("t1_word", bus.out_word, 7'b0000111);
        drain();

        // 2: count 0 then count 7, in_valid held; second acceptance lands on the first word's last beat.
        cycle(1'b1, 4'd0, 1'b1, acc);
        t0 = cyc;
        t1 = -1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 4'd7, 1'b1, acc);
            if (acc) begin
                t1 = cyc;
                break;
            end
        end
        chk("t2_b2b_gap", t1 - t0, 7);
        drain();

        // 3: count 5 with out_ready pattern 1,0,0,1,0,0,...
        cycle(1'b1, 4'd5, 1'b1, acc);
        for (int k = 0; k < 60 && sb.size() > 0; k++) cycle(1'b0, 4'd0, (k % 3) == 0, acc);
        chk("t3_drained", sb.size(), 0);

        // 4: in-range 7, then over-range 9 which saturates and pulses sat_err once.
        cycle(1'b1, 4'd7, 1'b1, acc);
        drain();
        cycle(1'b1, 4'd9, 1'b1, acc);
        chk("t4_sat_word", bus.out_word, model_word(7, model_off));
        drain();

        // 5: reset after beat 3 of count 4 aborts the word.
        cycle(1'b1, 4'd4, 1'b1, acc);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'd0, 1'b1, acc);
        do_reset();
        cycle(1'b1, 4'd2, 1'b1, acc);
        chk("t5_word", bus.out_word, 7'b0000011);
        drain();

        // 6: three words of count 2; the ones move along when rotation is built in.
        exp6[0] = 7'b0000011;
        exp6[1] = ROT ? 7'b0000110 : 7'b0000011;
        exp6[2] = ROT ? 7'b0001100 : 7'b0000011;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            cycle(1'b1, 4'd2, 1'b1, acc);
            chk("t6_word", bus.out_word, exp6[n]);
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
